// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the clear-sequencer state encoding, address-width helper and priority select.
package rf_pkg;

    typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;

    localparam int RF_MAX_PORTS = 8;
    localparam int RF_SEL_W     = 3;

    typedef struct packed {
        logic                hit;
        logic [RF_SEL_W-1:0] idx;
    } rf_sel_t;

    function automatic int rf_addr_w(input int nregs);
        return $clog2(nregs);
    endfunction

    // The highest set bit wins, so the youngest matching write port is selected.
    function automatic rf_sel_t rf_prio_sel(input logic [RF_MAX_PORTS-1:0] match);
        rf_sel_t s;
        s = '0;
        for (int i = 0; i < RF_MAX_PORTS; i++) begin
            if (match[i]) begin
                s.hit = 1'b1;
                s.idx = RF_SEL_W'(i);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/rf_mp_if.sv
// Read/write port bundle of the register file; RF_SCOREBOARD_EN adds the alloc/pending signals.
interface rf_mp_if
    import rf_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2
);
    localparam int AW = rf_addr_w(NREGS);

    logic                   o_ready;
    logic [NREAD*AW-1:0]    i_raddr;
    logic [NREAD*XLEN-1:0]  o_rdata;
    logic [NWRITE-1:0]      i_wen;
    logic [NWRITE*AW-1:0]   i_waddr;
    logic [NWRITE*XLEN-1:0] i_wdata;
`ifdef RF_SCOREBOARD_EN
    logic                   i_alloc_en;
    logic [AW-1:0]          i_alloc_addr;
    logic [NREAD-1:0]       o_pending;
`endif

    modport master (
        output i_raddr, i_wen, i_waddr, i_wdata,
`ifdef RF_SCOREBOARD_EN
        output i_alloc_en, i_alloc_addr,
        input  o_pending,
`endif
        input  o_ready, o_rdata
    );

    modport slave (
        input  i_raddr, i_wen, i_waddr, i_wdata,
`ifdef RF_SCOREBOARD_EN
        input  i_alloc_en, i_alloc_addr,
        output o_pending,
`endif
        output o_ready, o_rdata
    );

endinterface

// File: rtl/rf_clear_seq.sv
// Post-reset clear sequencer: walks entries 1..NREGS-1 writing zero, then raises ready.
// Latency: ready rises NREGS-1 edges after reset release.
// Backpressure: none; the array ignores port writes while clearing.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    output logic                        ready,
    output logic                        clear_we,
    output logic [rf_addr_w(NREGS)-1:0] clear_addr
);
    localparam int AW = rf_addr_w(NREGS);

    rf_state_t     state;
    logic [AW-1:0] cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= RF_CLEAR;
            cnt   <= AW'(1);
            ready <= 1'b0;
        end else begin
            case (state)
                RF_CLEAR: begin
                    if (cnt == AW'(NREGS - 1)) begin
                        state <= RF_RUN;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                RF_RUN:  state <= RF_RUN;
                default: state <= RF_CLEAR;
            endcase
        end
    end

    assign clear_we   = (state == RF_CLEAR);
    assign clear_addr = cnt;

endmodule

// File: rtl/rf_mp.sv
// Multi-port register file: NREAD combinational reads, NWRITE synchronous writes, entry 0 reads zero.
// Latency: writes land on the edge; reads are same-cycle, with optional write bypass (BYPASS_EN).
// Backpressure: none; o_ready low during the post-reset clear. Optional: RF_SCOREBOARD_EN.
module rf_mp
    import rf_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int NREAD     = 2,
    parameter int NWRITE    = 2,
    parameter int BYPASS_EN = 0
) (
    input  logic   i_clk,
    input  logic   i_rst,
    rf_mp_if.slave bus
);
    localparam int AW = rf_addr_w(NREGS);

    logic          ready;
    logic          clear_we;
    logic [AW-1:0] clear_addr;

    logic [XLEN-1:0] mem [NREGS];

    rf_clear_seq #(.NREGS(NREGS)) u_clear (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .ready      (ready),
        .clear_we   (clear_we),
        .clear_addr (clear_addr)
    );

    assign bus.o_ready = ready;

    // No reset on the array itself; the clear walk zeroes it instead.
    // Later loop iterations override earlier ones, so the highest-index port wins.
    always_ff @(posedge i_clk) begin
        if (clear_we) begin
            mem[clear_addr] <= '0;
        end else begin
            for (int w = 0; w < NWRITE; w++) begin
                if (bus.i_wen[w] && bus.i_waddr[w*AW +: AW] != '0)
                    mem[bus.i_waddr[w*AW +: AW]] <= bus.i_wdata[w*XLEN +: XLEN];
            end
        end
    end

`ifdef RF_SCOREBOARD_EN
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_nxt;
    logic [NREAD-1:0] pend_c;

    // Alloc is applied after the write clears because it belongs to a younger instruction.
    always_comb begin
        pending_nxt = pending;
        for (int w = 0; w < NWRITE; w++) begin
            if (bus.i_wen[w])
                pending_nxt[bus.i_waddr[w*AW +: AW]] = 1'b0;
        end
        if (bus.i_alloc_en)
            pending_nxt[bus.i_alloc_addr] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            pending <= '0;
        else if (!ready)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

    assign bus.o_pending = pend_c;
`endif

    logic [NREAD*XLEN-1:0]   rdata_c;
    logic [AW-1:0]           ra;
    logic [XLEN-1:0]         rd;
    logic [RF_MAX_PORTS-1:0] match;
    rf_sel_t                 sel;

    always_comb begin
        rdata_c = '0;
        ra      = '0;
        rd      = '0;
        match   = '0;
        sel     = '0;
`ifdef RF_SCOREBOARD_EN
        pend_c  = '0;
`endif
        for (int r = 0; r < NREAD; r++) begin
            ra    = bus.i_raddr[r*AW +: AW];
            match = '0;
            for (int w = 0; w < NWRITE; w++) begin
                if (BYPASS_EN != 0 && bus.i_wen[w] && bus.i_waddr[w*AW +: AW] == ra)
                    match[w] = 1'b1;
            end
            sel = rf_prio_sel(match);
            rd  = mem[ra];
            if (sel.hit)
                rd = bus.i_wdata[int'(sel.idx)*XLEN +: XLEN];
            if (!ready || ra == '0)
                rd = '0;
            rdata_c[r*XLEN +: XLEN] = rd;
`ifdef RF_SCOREBOARD_EN
            pend_c[r] = ready && pending[ra] && !sel.hit;
`endif
        end
    end

    assign bus.o_rdata = rdata_c;

endmodule

// File: tb/tb_rf_mp.sv
// Directed bench for rf_mp: runs a BYPASS_EN=0 and a BYPASS_EN=1 instance side by side.
// Expectations are queued as stimulus is applied and popped when outputs are sampled.
module tb_rf_mp;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_mp_if #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2)) bus0 ();
    rf_mp_if #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2)) bus1 ();

    rf_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS_EN(0)) dut0 (
        .i_clk (clk), .i_rst (rst), .bus (bus0)
    );
    rf_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS_EN(1)) dut1 (
        .i_clk (clk), .i_rst (rst), .bus (bus1)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic expect_v(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic observe(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_underflow observed=%h expected=none", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
        end
    endtask

    task automatic drv(input logic [1:0] wen, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic [4:0] ra0, input logic [4:0] ra1);
        bus0.i_wen = wen;  bus0.i_waddr = {wa1, wa0}; bus0.i_wdata = {wd1, wd0}; bus0.i_raddr = {ra1, ra0};
        bus1.i_wen = wen;  bus1.i_waddr = {wa1, wa0}; bus1.i_wdata = {wd1, wd0}; bus1.i_raddr = {ra1, ra0};
    endtask

    task automatic chk_rd(input string tag, input int p, input logic [31:0] e0, input logic [31:0] e1);
        expect_v({tag, "_nobyp"}, e0);
        expect_v({tag, "_byp"}, e1);
        observe(bus0.o_rdata[p*32 +: 32]);
        observe(bus1.o_rdata[p*32 +: 32]);
    endtask

    task automatic chk_ready(input string tag, input logic e);
        expect_v({tag, "_nobyp"}, {31'd0, e});
        expect_v({tag, "_byp"}, {31'd0, e});
        observe({31'd0, bus0.o_ready});
        observe({31'd0, bus1.o_ready});
    endtask

`ifdef RF_SCOREBOARD_EN
    task automatic alloc(input logic en, input logic [4:0] a);
        bus0.i_alloc_en = en; bus0.i_alloc_addr = a;
        bus1.i_alloc_en = en; bus1.i_alloc_addr = a;
    endtask

    task automatic chk_pend(input string tag, input logic e0, input logic e1);
        expect_v({tag, "_nobyp"}, {31'd0, e0});
        expect_v({tag, "_byp"}, {31'd0, e1});
        observe({31'd0, bus0.o_pending[0]});
        observe({31'd0, bus1.o_pending[0]});
    endtask
`endif

    // Caller releases reset on a negedge; ready must appear on the 31st following edge.
    // Port 0 keeps writing entry 2 throughout; those writes must be dropped.
    task automatic run_clear(input string tag);
        drv(2'b01, 5'd2, 32'hCAFE_F00D, 5'd0, 32'd0, 5'd2, 5'd0);
        for (int e = 1; e <= 31; e++) begin
            @(posedge clk);
            #1;
            chk_ready(tag, (e == 31));
            if (e < 31) chk_rd({tag, "_rd_in_clear"}, 0, 32'd0, 32'd0);
        end
        drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd2, 5'd0);
        #1;
        chk_rd({tag, "_entry2_cleared"}, 0, 32'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd0);
`ifdef RF_SCOREBOARD_EN
        alloc(1'b0, 5'd0);
`endif
        repeat (3) @(negedge clk);
        #1;
        chk_ready("ready_in_reset", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_clear("clear1");

        // Two writes to entry 5 in one cycle: port 1 (younger) wins.
        @(negedge clk);
        drv(2'b11, 5'd5, 32'hDEAD_BEEF, 5'd5, 32'h1234_5678, 5'd5, 5'd5);
        #1;
        chk_rd("dual_wr5_same_cycle", 0, 32'd0, 32'h1234_5678);
        @(negedge clk);
        drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 5'd5);
        #1;
        chk_rd("dual_wr5_p0", 0, 32'h1234_5678, 32'h1234_5678);
        chk_rd("dual_wr5_p1", 1, 32'h1234_5678, 32'h1234_5678);

        @(negedge clk);
        drv(2'b10, 5'd0, 32'd0, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd5);
        #1;
        chk_rd("byp_wr7", 0, 32'd0, 32'hA5A5_A5A5);
        chk_rd("byp_wr7_other_port", 1, 32'h1234_5678, 32'h1234_5678);
        @(negedge clk);
        drv(2'b01, 5'd7, 32'h1111_1111, 5'd0, 32'd0, 5'd7, 5'd7);
        #1;
        chk_rd("overwrite7_same_cycle", 0, 32'hA5A5_A5A5, 32'h1111_1111);
        @(negedge clk);
        drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd7, 5'd5);
        #1;
        chk_rd("overwrite7_after", 0, 32'h1111_1111, 32'h1111_1111);
        chk_rd("entry5_kept", 1, 32'h1234_5678, 32'h1234_5678);

        @(negedge clk);
        drv(2'b11, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        #1;
        chk_rd("wr0_same_cycle_p0", 0, 32'd0, 32'd0);
        chk_rd("wr0_same_cycle_p1", 1, 32'd0, 32'd0);
        @(negedge clk);
        drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd0);
        #1;
        chk_rd("wr0_after", 0, 32'd0, 32'd0);

        // Distinct bypass targets per read port, then a lower-port-only match.
        @(negedge clk);
        drv(2'b11, 5'd9, 32'h0909_0909, 5'd10, 32'h1010_1010, 5'd9, 5'd10);
        #1;
        chk_rd("byp_split_p0", 0, 32'd0, 32'h0909_0909);
        chk_rd("byp_split_p1", 1, 32'd0, 32'h1010_1010);
        @(negedge clk);
        drv(2'b11, 5'd9, 32'h9999_9999, 5'd5, 32'h5555_5555, 5'd9, 5'd9);
        #1;
        chk_rd("byp_low_port_only", 0, 32'h0909_0909, 32'h9999_9999);
        @(negedge clk);
        drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 5'd5);
        #1;
        chk_rd("after_low_port_p0", 0, 32'h9999_9999, 32'h9999_9999);
        chk_rd("after_low_port_p1", 1, 32'h5555_5555, 32'h5555_5555);

`ifdef RF_SCOREBOARD_EN
        @(negedge clk);
        drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd3);
        alloc(1'b1, 5'd3);
        #1;
        chk_pend("pend3_before_edge", 1'b0, 1'b0);
        @(negedge clk);
        alloc(1'b0, 5'd0);
        #1;
        chk_pend("pend3_set", 1'b1, 1'b1);
        @(negedge clk);
        drv(2'b01, 5'd3, 32'h33, 5'd0, 32'd0, 5'd3, 5'd3);
        alloc(1'b1, 5'd3);
        #1;
        chk_pend("pend3_wr_alloc_same_cycle", 1'b1, 1'b0);
        @(negedge clk);
        drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd3);
        alloc(1'b0, 5'd0);
        #1;
        chk_pend("pend3_alloc_wins", 1'b1, 1'b1);
        @(negedge clk);
        drv(2'b10, 5'd0, 32'd0, 5'd3, 32'h44, 5'd3, 5'd3);
        #1;
        chk_pend("pend3_wr_same_cycle", 1'b1, 1'b0);
        @(negedge clk);
        drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 5'd3);
        #1;
        chk_pend("pend3_cleared", 1'b0, 1'b0);
        @(negedge clk);
        drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd4, 5'd4);
        alloc(1'b1, 5'd4);
        @(negedge clk);
        alloc(1'b0, 5'd0);
        #1;
        chk_pend("pend4_set", 1'b1, 1'b1);
`endif

        // Reset while running drops ready before any clock edge.
        @(negedge clk);
        drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 5'd5);
        #2;
        rst = 1'b1;
        #1;
        chk_ready("ready_async_drop", 1'b0);
        chk_rd("rd_after_reset", 0, 32'd0, 32'd0);
`ifdef RF_SCOREBOARD_EN
        drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd4, 5'd4);
        #1;
        chk_pend("pend_reset_cleared", 1'b0, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk_ready("ready_at_cnt10", 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk_ready("ready_mid_clear_reset", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_clear("clear2");
        @(negedge clk);
        drv(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 5'd7);
        #1;
        chk_rd("entry5_recleared", 0, 32'd0, 32'd0);
        chk_rd("entry7_recleared", 1, 32'd0, 32'd0);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
